// File: rtl/icache_req_pipe.sv
// Request pipeline stage between icache lookup and tag-compare. Registers the request bundle
// under valid/ready with kill/flush squash and a stall counter; ICACHE_REQ_PIPE_SKID_EN adds a skid register.
module icache_req_pipe #(
  parameter  int VADDR_SIZE  = 40,
  parameter  int IDX_BITS    = 12,
  parameter  int VPN_BITS    = 28,
  parameter  int TAG_WIDTH   = 20,
  parameter  int N_WAY       = 4,
  parameter  int TRESP_WIDTH = 23,
  parameter  int STALL_CNT_W = 8,
  localparam int WAY_W       = (N_WAY > 1) ? $clog2(N_WAY) : 1
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [VADDR_SIZE-1:0]  vaddr_i,
  input  logic [IDX_BITS-1:0]    idx_i,
  input  logic [VPN_BITS-1:0]    vpn_i,
  input  logic [TAG_WIDTH-1:0]   cline_tag_i,
  input  logic [WAY_W-1:0]       way_i,
  input  logic                   cmp_enable_i,
  input  logic [TRESP_WIDTH-1:0] mmu_tresp_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [VADDR_SIZE-1:0]  vaddr_o,
  output logic [IDX_BITS-1:0]    idx_o,
  output logic [VPN_BITS-1:0]    vpn_o,
  output logic [TAG_WIDTH-1:0]   cline_tag_o,
  output logic [WAY_W-1:0]       way_o,
  output logic                   cmp_enable_o,
  output logic [TRESP_WIDTH-1:0] mmu_tresp_o,
  input  logic                   kill_i,
  input  logic                   flush_i,
  output logic                   flush_o,
  input  logic                   cache_enable_i,
  output logic                   cache_enable_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef struct packed {
    logic [VADDR_SIZE-1:0]  vaddr;
    logic [IDX_BITS-1:0]    idx;
    logic [VPN_BITS-1:0]    vpn;
    logic [TAG_WIDTH-1:0]   tag;
    logic [WAY_W-1:0]       way;
    logic                   cmp;
    logic [TRESP_WIDTH-1:0] tresp;
  } req_t;

  req_t                   w_in, r_m;
  logic                   w_m_valid, w_squash, w_accept, w_deliver;
  logic                   r_flush, r_cache_en;
  logic [STALL_CNT_W-1:0] r_stall;

  assign w_in      = '{vaddr: vaddr_i, idx: idx_i, vpn: vpn_i, tag: cline_tag_i,
                       way: way_i, cmp: cmp_enable_i, tresp: mmu_tresp_i};
  assign w_squash  = kill_i || flush_i;
  assign w_accept  = in_valid_i && in_ready_o;
  assign w_deliver = w_m_valid && out_ready_i;

`ifdef ICACHE_REQ_PIPE_SKID_EN
  // Bit 1 of the state is s_valid and bit 0 is m_valid, so in_ready_o comes straight off a flop.
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_e;
  state_e r_state, w_state_nxt;
  req_t   r_s;
  logic   w_ld_m_in, w_ld_m_s, w_ld_s;

  assign w_m_valid  = r_state[0];
  assign in_ready_o = !r_state[1];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= EMPTY;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_m_in   = 1'b0;
    w_ld_m_s    = 1'b0;
    w_ld_s      = 1'b0;
    if (w_squash) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_accept) begin
          w_state_nxt = ONE;
          w_ld_m_in   = 1'b1;
        end
        ONE: begin
          if (w_accept && w_deliver) begin
            w_ld_m_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = FULL;
            w_ld_s      = 1'b1;
          end else if (w_deliver) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: if (w_deliver) begin
          w_state_nxt = ONE;
          w_ld_m_s    = 1'b1;
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_m <= '0;
      r_s <= '0;
    end else begin
      if (w_ld_m_in)     r_m <= w_in;
      else if (w_ld_m_s) r_m <= r_s;
      if (w_ld_s)        r_s <= w_in;
    end
  end
`else
  logic r_m_valid;

  assign w_m_valid  = r_m_valid;
  assign in_ready_o = !r_m_valid || out_ready_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)        r_m_valid <= 1'b0;
    else if (w_squash)  r_m_valid <= 1'b0;
    else if (w_accept)  r_m_valid <= 1'b1;
    else if (w_deliver) r_m_valid <= 1'b0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                    r_m <= '0;
    else if (w_accept && !w_squash) r_m <= w_in;
  end
`endif

  // Counts back-pressure on the beat currently presented; restarts for each new beat.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                   r_stall <= '0;
    else if (w_squash || w_deliver) r_stall <= '0;
    else if (w_m_valid && r_stall != {STALL_CNT_W{1'b1}}) r_stall <= r_stall + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_flush    <= 1'b0;
      r_cache_en <= 1'b0;
    end else begin
      r_flush    <= flush_i;
      r_cache_en <= cache_enable_i;
    end
  end

  assign out_valid_o    = w_m_valid;
  assign vaddr_o        = r_m.vaddr;
  assign idx_o          = r_m.idx;
  assign vpn_o          = r_m.vpn;
  assign cline_tag_o    = r_m.tag;
  assign way_o          = r_m.way;
  assign cmp_enable_o   = r_m.cmp;
  assign mmu_tresp_o    = r_m.tresp;
  assign flush_o        = r_flush;
  assign cache_enable_o = r_cache_en;
  assign stall_cnt_o    = r_stall;

endmodule

// File: tb/tb_icache_req_pipe.sv
// Scoreboard bench for icache_req_pipe: driver pushes accepted beats, a negedge monitor checks outputs.
module tb_icache_req_pipe;
`ifdef ICACHE_REQ_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int BW = 126;
  localparam int STALL_MAX = 255;

  logic clk_i = 1'b0, rstn_i = 1'b0;
  logic in_valid_i = 0, in_ready_o, out_valid_o, out_ready_i = 0;
  logic kill_i = 0, flush_i = 0, flush_o, cache_enable_i = 0, cache_enable_o;
  logic [39:0] vaddr_i = '0, vaddr_o;
  logic [11:0] idx_i = '0, idx_o;
  logic [27:0] vpn_i = '0, vpn_o;
  logic [19:0] cline_tag_i = '0, cline_tag_o;
  logic [1:0]  way_i = '0, way_o;
  logic        cmp_enable_i = 0, cmp_enable_o;
  logic [22:0] mmu_tresp_i = '0, mmu_tresp_o;
  logic [7:0]  stall_cnt_o;

  icache_req_pipe dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .vaddr_i(vaddr_i), .idx_i(idx_i), .vpn_i(vpn_i), .cline_tag_i(cline_tag_i), .way_i(way_i),
    .cmp_enable_i(cmp_enable_i), .mmu_tresp_i(mmu_tresp_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .vaddr_o(vaddr_o), .idx_o(idx_o), .vpn_o(vpn_o),
    .cline_tag_o(cline_tag_o), .way_o(way_o), .cmp_enable_o(cmp_enable_o), .mmu_tresp_o(mmu_tresp_o),
    .kill_i(kill_i), .flush_i(flush_i), .flush_o(flush_o), .cache_enable_i(cache_enable_i),
    .cache_enable_o(cache_enable_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;
  logic [BW-1:0] exp_q[$];
  bit   exp_rdy = 1'b1, exp_flush = 1'b0, exp_ce = 1'b0, mon_en = 1'b0;
  int   exp_stall = 0;
  logic [BW-1:0] w_out;
  assign w_out = {vaddr_o, idx_o, vpn_o, cline_tag_o, way_o, cmp_enable_o, mmu_tresp_o};

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [BW-1:0] rnd_beat();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[BW-1:0];
  endfunction

  // Monitor: every settled cycle, compare against the queue-based model.
  always @(negedge clk_i) begin
    if (rstn_i && mon_en) begin
      chk("in_ready", {127'd0, in_ready_o}, {127'd0, exp_rdy});
      chk("out_valid", {127'd0, out_valid_o}, {127'd0, exp_q.size() != 0});
      chk("stall_cnt", {120'd0, stall_cnt_o}, 128'(exp_stall));
      chk("flush_o", {127'd0, flush_o}, {127'd0, exp_flush});
      chk("cache_en_o", {127'd0, cache_enable_o}, {127'd0, exp_ce});
      if (out_valid_o && exp_q.size() != 0) begin
        chk("payload", {2'b00, w_out}, {2'b00, exp_q[0]});
        if (out_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus; the model is advanced after the monitor has sampled.
  task automatic step(input bit iv, input bit ordy, input bit k, input bit f, input bit ce,
                      input logic [BW-1:0] b);
    int occ;
    @(posedge clk_i); #1;
    if (k || f) ordy = 1'b0;
    in_valid_i = iv; out_ready_i = ordy; kill_i = k; flush_i = f; cache_enable_i = ce;
    {vaddr_i, idx_i, vpn_i, cline_tag_i, way_i, cmp_enable_i, mmu_tresp_i} = b;
    occ = exp_q.size();
    exp_rdy = SKID ? (occ < 2) : (occ == 0 || ordy);
    @(negedge clk_i); #1;
    if (k || f) exp_q.delete();
    else if (iv && exp_rdy) exp_q.push_back(b);
    if (k || f || (occ > 0 && ordy)) exp_stall = 0;
    else if (occ > 0 && exp_stall < STALL_MAX) exp_stall++;
    exp_flush = f;
    exp_ce = ce;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, ordy, 1'b0, 1'b0, cache_enable_i, rnd_beat());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] b;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_out_valid", {127'd0, out_valid_o}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready_o}, 128'd1);
    chk("rst_vaddr", {88'd0, vaddr_o}, 128'd0);
    chk("rst_stall", {120'd0, stall_cnt_o}, 128'd0);
    chk("rst_flush_ce", {126'd0, flush_o, cache_enable_o}, 128'd0);
    @(negedge clk_i); rstn_i = 1'b1; mon_en = 1'b1;
    #1;
    chk("rel_in_ready", {127'd0, in_ready_o}, 128'd1);
    chk("rel_out_valid", {127'd0, out_valid_o}, 128'd0);

    // First beat: one-cycle latency.
    b = rnd_beat(); b[BW-1 -: 40] = 40'h12_3456_7890;
    step(1, 1, 0, 0, 0, b);
    idle(1);
    chk("lat_valid", {127'd0, out_valid_o}, 128'd1);
    chk("lat_vaddr", {88'd0, vaddr_o}, 128'h12_3456_7890);
    idle(1);

    // Back-to-back stream with no bubbles.
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0, rnd_beat());
    for (int i = 0; i < 8; i++) begin
      if (i > 0) chk("stream_valid", {127'd0, out_valid_o}, 128'd1);
      if (i == 0) idle(1);
    end
    idle(1);

    // Long stall: counter saturates, payload held (checked by monitor each cycle).
    step(1, 0, 0, 0, 0, rnd_beat());
    for (int i = 0; i < 300; i++) idle(0);
    chk("stall_sat", {120'd0, stall_cnt_o}, 128'd255);
    idle(1);
    idle(0);
    chk("stall_clr", {120'd0, stall_cnt_o}, 128'd0);

    // Fill (both entries with skid), then kill with a concurrent accept attempt.
    step(1, 0, 0, 0, 0, rnd_beat());
    step(1, 0, 0, 0, 0, rnd_beat());
    idle(0);
    if (SKID) chk("skid_full_rdy", {127'd0, in_ready_o}, 128'd0);
    step(1, 0, 1, 0, 0, rnd_beat());
    idle(1);
    chk("kill_valid", {127'd0, out_valid_o}, 128'd0);
    chk("kill_stall", {120'd0, stall_cnt_o}, 128'd0);
    idle(1);

    // Skid drain order: A then B.
    step(1, 0, 0, 0, 0, rnd_beat());
    step(1, 0, 0, 0, 0, rnd_beat());
    idle(1);
    idle(1);
    idle(1);
    chk("drain_rdy", {127'd0, in_ready_o}, 128'd1);
    chk("drain_empty", {127'd0, out_valid_o}, 128'd0);

    // Flush pulse: flush_o for exactly one cycle, valids cleared.
    step(1, 0, 0, 0, 0, rnd_beat());
    step(0, 0, 0, 1, 0, rnd_beat());
    idle(1);
    chk("flush_hi", {127'd0, flush_o}, 128'd1);
    chk("flush_valid", {127'd0, out_valid_o}, 128'd0);
    idle(1);
    chk("flush_lo", {127'd0, flush_o}, 128'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1, rnd_beat());

    // Asynchronous reset mid-stream drops beats without a clock edge.
    step(1, 0, 0, 0, 1, rnd_beat());
    step(1, 0, 0, 0, 1, rnd_beat());
    @(posedge clk_i); #3;
    rstn_i = 1'b0;
    #1;
    chk("arst_valid", {127'd0, out_valid_o}, 128'd0);
    chk("arst_ready", {127'd0, in_ready_o}, 128'd1);
    chk("arst_ce", {127'd0, cache_enable_o}, 128'd0);
    in_valid_i = 0; out_ready_i = 0; kill_i = 0; flush_i = 0; cache_enable_i = 0;
    exp_q.delete(); exp_stall = 0; exp_flush = 0; exp_ce = 0; exp_rdy = 1;
    @(posedge clk_i); @(negedge clk_i); #1;
    rstn_i = 1'b1;
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, 0, $urandom_range(0, 1) == 1,
           rnd_beat());
    for (int i = 0; i < 4; i++) idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/icache_req_pipe.md
# icache_req_pipe

Parametrised request pipeline stage between the icache lookup stage and the tag-compare/response stage. Registers the full in-flight request bundle (virtual address, index, VPN, cacheline tag, replacement way, compare enable, MMU translation response) under a valid/ready handshake. Adds back-pressure, kill/flush squashing and a saturating stall counter. An optional skid buffer gives a fully registered `in_ready_o`.

## Interface
Parameters:
- `VADDR_SIZE`, 40, virtual address width
- `IDX_BITS`, 12, icache index width
- `VPN_BITS`, 28, virtual page number width
- `TAG_WIDTH`, 20, cacheline tag width
- `N_WAY`, 4, associativity; way field is `$clog2(N_WAY)` bits, minimum 1
- `TRESP_WIDTH`, 23, MMU translation response width
- `STALL_CNT_W`, 8, stall counter width

Ports:
- Clock `clk_i` and reset `rstn_i`: one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock
- `rstn_i`  in  1  asynchronous active-low reset
- `in_valid_i`  in  1  upstream beat valid
- `in_ready_o`  out  1  stage can accept a beat
- `vaddr_i` / `vaddr_o`  in/out  VADDR_SIZE  virtual address
- `idx_i` / `idx_o`  in/out  IDX_BITS  cache index
- `vpn_i` / `vpn_o`  in/out  VPN_BITS  virtual page number
- `cline_tag_i` / `cline_tag_o`  in/out  TAG_WIDTH  cacheline tag
- `way_i` / `way_o`  in/out  $clog2(N_WAY)  way to replace
- `cmp_enable_i` / `cmp_enable_o`  in/out  1  tag compare enable
- `mmu_tresp_i` / `mmu_tresp_o`  in/out  TRESP_WIDTH  MMU translation response
- `out_valid_o`  out  1  downstream beat valid
- `out_ready_i`  in  1  downstream accepts
- `kill_i`  in  1  squash all in-flight beats
- `flush_i`  in  1  cache flush request
- `flush_o`  out  1  flush, registered
- `cache_enable_i` / `cache_enable_o`  in/out  1  cache enable, registered every cycle
- `stall_cnt_o`  out  STALL_CNT_W  consecutive back-pressure cycles on the current output beat

## Operation
- Handshake: accept = `in_valid_i && in_ready_o`; deliver = `out_valid_o && out_ready_i`.
- The output payload is held stable while `out_valid_o && !out_ready_i`.
- Main register M holds the output payload plus `m_valid`, and drives `out_valid_o` and the `*_o` payload.
- Without skid (`in_ready_o = !m_valid || out_ready_i`):
  - On accept: M takes the input and `m_valid` is set to 1.
  - On deliver without accept: `m_valid` is set to 0.
- With skid: see Configuration.
- Kill: `kill_i || flush_i` is the squash condition. On squash, all valids clear at the next edge. A beat accepted in the squash cycle is consumed and discarded. Payload registers may keep their old values.
- `flush_o` is `flush_i` delayed one cycle. `cache_enable_o` is `cache_enable_i` delayed one cycle. Neither depends on the handshake.
- Stall counter:
  - Increments on each cycle with `out_valid_o && !out_ready_i`.
  - Saturates at 2^STALL_CNT_W−1.
  - Clears to 0 on deliver or squash.
  - Holds otherwise.
- Reset: all registers clear to 0, so every output is 0 except `in_ready_o`, which is 1.

## Timing
- Latency: 1 cycle from accept to `out_valid_o` when M is empty or being delivered.
- Full throughput: 1 beat per cycle with `out_ready_i` held high.
- Squash takes priority over accept, deliver and skid refill in the same cycle.
- Reset asserted mid-operation drops all beats immediately, without waiting for a clock edge.

## Configuration
- Macro: `ICACHE_REQ_PIPE_SKID_EN`.
- Defined: a second register S with `s_valid` is added, and `in_ready_o = !s_valid`, a pure register output. State machine:
  - EMPTY (m=0, s=0): accept moves to ONE.
  - ONE (m=1, s=0), transitions:
    - Accept and deliver: stay in ONE, M is replaced by the new beat.
    - Accept without deliver: go to FULL, S takes the new beat.
    - Deliver without accept: go to EMPTY.
  - FULL (m=1, s=1): deliver moves to ONE with M taking S. No accept is possible.
  - Squash from any state goes to EMPTY.
- Undefined: there is no S. `in_ready_o` is combinational from `out_ready_i`, with one-entry behaviour as described in Operation.

## Test plan
- Reset, then release: all outputs 0 and `in_ready_o` = 1. Present vaddr 0x12_3456_7890 with `out_ready_i` = 1 → one cycle later `out_valid_o` = 1 and `vaddr_o` = 0x1234567890.
- Back-to-back stream of 8 beats with `out_ready_i` = 1 → 8 consecutive deliveries in order and no bubbles.
- Hold `out_ready_i` = 0 for 300 cycles with one beat in M:
  - `stall_cnt_o` saturates at 255 and the payload stays stable.
  - When `out_ready_i` rises, the beat is delivered and `stall_cnt_o` = 0 the next cycle.
- Skid build, with the macro defined:
  - Accept beats A and B while `out_ready_i` = 0 → `in_ready_o` = 0.
  - Raise `out_ready_i` → A is delivered, then B on the next cycle, and `in_ready_o` returns to 1.
- `kill_i` pulsed while FULL, with a simultaneous accept attempt → next cycle `out_valid_o` = 0, no beat is ever delivered, and `stall_cnt_o` = 0.
- `flush_i` pulse in cycle N → `flush_o` = 1 in cycle N+1 only, and all valids are cleared.
- Toggling `cache_enable_i` → `cache_enable_o` follows one cycle later, independent of handshake state.
